// File: rtl/mau_pkg.sv
// Shared types and defaults for the memory access unit: size encoding,
// FSM states and the default data-memory depth.
package mau_pkg;

  localparam int MAU_SIZE_DM_DEFAULT = 128;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundles the request, memory-port and response signals of the memory access unit.
// The slave modport is the unit's view; the master modport is the pipeline/memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/mau_lane_align.sv
// Combinational lane logic: load lane select with sign/zero extension, and
// sub-word store merge of new data into an existing memory word.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  size_e       size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh = {addr_lo_i, 3'b000};
  assign half_sh = {addr_lo_i[1], 4'b0000};
  assign byte_v  = 8'(word_i >> byte_sh);
  assign half_v  = 16'(word_i >> half_sh);

  always_comb begin
    load_data_o  = word_i;
    store_word_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o  = uns_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        store_word_o = (word_i & ~(32'h0000_00FF << byte_sh))
                     | ({24'h0, wdata_i[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_data_o  = uns_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        store_word_o = (word_i & ~(32'h0000_FFFF << half_sh))
                     | ({16'h0, wdata_i[15:0]} << half_sh);
      end
      default: begin
        load_data_o  = word_i;
        store_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed memory; sub-word stores use read-modify-write.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned/reserved-size requests instead of force-aligning.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int SIZE_DM = MAU_SIZE_DM_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  localparam logic [31:0] SIZE_DM_W = 32'(SIZE_DM);

  state_e      state_q;
  logic        we_q;
  logic        uns_q;
  size_e       size_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  size_e       req_size_d;
  logic [31:0] req_addr_d;
  logic        misalign_d;
  logic        range_err_d;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // Normalise the incoming request: either flag misalignment or clear the low address bits.
  always_comb begin
    req_size_d = size_e'(bus.req_size);
    req_addr_d = bus.req_addr;
    misalign_d = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    case (req_size_d)
      SZ_HALF: misalign_d = bus.req_addr[0];
      SZ_WORD: misalign_d = |bus.req_addr[1:0];
      SZ_RSVD: misalign_d = 1'b1;
      default: misalign_d = 1'b0;
    endcase
`else
    if (req_size_d == SZ_RSVD) begin
      req_size_d = SZ_WORD;
    end
    case (req_size_d)
      SZ_HALF: req_addr_d[0]   = 1'b0;
      SZ_WORD: req_addr_d[1:0] = 2'b00;
      default: req_addr_d      = bus.req_addr;
    endcase
`endif
  end

  assign range_err_d = ((bus.req_addr >> 2) >= SIZE_DM_W);

  mau_lane_align u_lane_align (
    .word_i       (bus.mem_rdata),
    .addr_lo_i    (addr_lo_q),
    .size_i       (size_q),
    .uns_i        (uns_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SZ_BYTE;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q         <= bus.req_we;
            uns_q        <= bus.req_unsigned;
            size_q       <= req_size_d;
            addr_lo_q    <= req_addr_d[1:0];
            wdata_q      <= bus.req_wdata;
            resp_rdata_q <= 32'h0;
            if (range_err_d || misalign_d) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              resp_err_q <= 1'b0;
              mem_addr_q <= req_addr_d >> 2;
              if (bus.req_we && (req_size_d == SZ_WORD)) begin
                mem_write_q <= 1'b1;
                mem_wdata_q <= bus.req_wdata;
                state_q     <= ST_WR;
              end else begin
                mem_read_q <= 1'b1;
                state_q    <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          mem_read_q <= 1'b0;
          if (we_q) begin
            // The merge is done against the word read this cycle, so WR writes it unchanged.
            mem_wdata_q <= store_word;
            mem_write_q <= 1'b1;
            state_q     <= ST_WR;
          end else begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        default: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 128-word memory model.
// Expectations follow MAU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   rd_cnt;
  int   wr_cnt;
  int   rd_snap;
  int   wr_snap;

  logic [31:0] mem [0:127];

  mem_access_unit_if bus ();

  mem_access_unit #(.SIZE_DM(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = (bus.mem_addr < 32'd128) ? mem[bus.mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < 32'd128) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
    if (bus.mem_read)  rd_cnt <= rd_cnt + 1;
    if (bus.mem_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in an idle cycle; returns #1 after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    chk("req_ready_before_issue", {31'b0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    $display("req we=%0d addr=%h size=%0d uns=%0d wdata=%h", we, addr, size, uns, wdata);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] exp);
    issue(1'b0, addr, size, uns, 32'h0);
    step();
    chk({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
    chk({tag, "_rdata"}, bus.resp_rdata, exp);
    chk({tag, "_err"},   {31'b0, bus.resp_err}, 32'd0);
    step();
  endtask

  task automatic err_chk(input string tag, input logic [31:0] addr, input logic [1:0] size);
    rd_snap = rd_cnt;
    wr_snap = wr_cnt;
    issue(1'b0, addr, size, 1'b0, 32'h0);
    chk({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
    chk({tag, "_err"},   {31'b0, bus.resp_err}, 32'd1);
    chk({tag, "_rd"},    {31'b0, bus.mem_read}, 32'd0);
    step();
    chk({tag, "_rdcnt"}, 32'(rd_cnt), 32'(rd_snap));
    chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'(wr_snap));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b1;

    #2;
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_mem_read",   {31'b0, bus.mem_read},   32'd0);
    chk("rst_mem_write",  {31'b0, bus.mem_write},  32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
    chk("rst_mem_addr",   bus.mem_addr,   32'h0);
    chk("rst_mem_wdata",  bus.mem_wdata,  32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Word store then word load at 0x10.
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
    chk("sw_write",  {31'b0, bus.mem_write}, 32'd1);
    chk("sw_read",   {31'b0, bus.mem_read},  32'd0);
    chk("sw_addr",   bus.mem_addr,  32'd4);
    chk("sw_wdata",  bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_valid_early", {31'b0, bus.resp_valid}, 32'd0);
    step();
    chk("sw_valid",  {31'b0, bus.resp_valid}, 32'd1);
    chk("sw_err",    {31'b0, bus.resp_err},   32'd0);
    chk("sw_rdata",  bus.resp_rdata, 32'h0);
    chk("sw_mem4",   mem[4], 32'hDEADBEEF);
    step();
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    chk("lw_read",   {31'b0, bus.mem_read}, 32'd1);
    chk("lw_addr",   bus.mem_addr, 32'd4);
    step();
    chk("lw_valid",  {31'b0, bus.resp_valid}, 32'd1);
    chk("lw_rdata",  bus.resp_rdata, 32'hDEADBEEF);
    chk("lw_err",    {31'b0, bus.resp_err}, 32'd0);
    step();

    // Sub-word store read-modify-write.
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344);
    step();
    step();
    issue(1'b1, 32'h12, 2'b00, 1'b0, 32'h000000AA);
    chk("sb_rd_read",  {31'b0, bus.mem_read},  32'd1);
    chk("sb_rd_write", {31'b0, bus.mem_write}, 32'd0);
    chk("sb_rd_addr",  bus.mem_addr, 32'd4);
    step();
    chk("sb_wr_write", {31'b0, bus.mem_write}, 32'd1);
    chk("sb_wr_read",  {31'b0, bus.mem_read},  32'd0);
    chk("sb_wr_wdata", bus.mem_wdata, 32'h11AA3344);
    chk("sb_wr_valid", {31'b0, bus.resp_valid}, 32'd0);
    step();
    chk("sb_valid",    {31'b0, bus.resp_valid}, 32'd1);
    chk("sb_rdata",    bus.resp_rdata, 32'h0);
    chk("sb_mem4",     mem[4], 32'h11AA3344);
    step();

    // Half store into upper lane, then sign/zero extension checks.
    issue(1'b1, 32'h12, 2'b01, 1'b0, 32'hFFFF5566);
    step();
    step();
    step();
    chk("sh_mem4", mem[4], 32'h55663344);
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h0000F080);
    step();
    step();
    load_chk("lb_s_10",  32'h10, 2'b00, 1'b0, 32'hFFFFFF80);
    load_chk("lh_u_10",  32'h10, 2'b01, 1'b1, 32'h0000F080);
    load_chk("lb_u_11",  32'h11, 2'b00, 1'b1, 32'h000000F0);
    load_chk("lh_s_10",  32'h10, 2'b01, 1'b0, 32'hFFFFF080);
    load_chk("lb_s_11",  32'h11, 2'b00, 1'b0, 32'hFFFFFFF0);
    load_chk("lh_s_12",  32'h12, 2'b01, 1'b0, 32'h00000000);

    // Errors and alignment handling.
    err_chk("err_idx128", 32'h200, 2'b10);
    err_chk("err_0x202",  32'h202, 2'b10);
`ifdef MAU_MISALIGN_TRAP_EN
    err_chk("mis_lw_12",  32'h12, 2'b10);
    err_chk("mis_lh_11",  32'h11, 2'b01);
    err_chk("rsvd_10",    32'h10, 2'b11);
`else
    load_chk("mis_lw_12", 32'h12, 2'b10, 1'b0, 32'h0000F080);
    load_chk("mis_lh_11", 32'h11, 2'b01, 1'b0, 32'hFFFFF080);
    load_chk("rsvd_10",   32'h10, 2'b11, 1'b0, 32'h0000F080);
`endif

    // Response back-pressure with a second request waiting.
    bus.resp_ready = 1'b0;
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    step();
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h14;
    bus.req_size  = 2'b10;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",     {31'b0, bus.resp_valid}, 32'd1);
      chk("bp_rdata",     bus.resp_rdata, 32'h0000F080);
      chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("bp_no_read",   {31'b0, bus.mem_read}, 32'd0);
      step();
    end
    bus.resp_ready = 1'b1;
    chk("bp_hs_valid", {31'b0, bus.resp_valid}, 32'd1);
    step();
    chk("bp_idle_ready", {31'b0, bus.req_ready},  32'd1);
    chk("bp_idle_valid", {31'b0, bus.resp_valid}, 32'd0);
    step();
    bus.req_valid = 1'b0;
    chk("bp_acc_read", {31'b0, bus.mem_read}, 32'd1);
    chk("bp_acc_addr", bus.mem_addr, 32'd5);
    step();
    step();

    // Reset during the RD phase of a sub-word store.
    issue(1'b1, 32'h14, 2'b00, 1'b0, 32'h00000055);
    chk("rst_mid_read", {31'b0, bus.mem_read}, 32'd1);
    wr_snap = wr_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_read_drop", {31'b0, bus.mem_read},  32'd0);
    chk("rst_mid_write",     {31'b0, bus.mem_write}, 32'd0);
    chk("rst_mid_ready",     {31'b0, bus.req_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rst_mid_wrcnt",  32'(wr_cnt), 32'(wr_snap));
    chk("rst_mid_ready2", {31'b0, bus.req_ready},  32'd1);
    chk("rst_mid_valid",  {31'b0, bus.resp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
